div_unit: RTL and testbench

- Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) in the EX stage, directly upstream of the register file write port.
- Accepts one operation from the EX decode, iterates one quotient bit per cycle, then issues a single-cycle register write-back (we/waddr/wdata) toward the register file.
- Drives busy_o so the pipeline control can stall the front end until the result has been written.

---
 rtl/div_unit_pkg.sv | 33 +++
 rtl/div_unit_if.sv | 28 ++
 rtl/div_unit.sv | 178 +++++++++++++++++
 tb/tb_div_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared core constants for the RV32M divider -- datapath and
// register-index widths, funct3 codes of the four divide ops, FSM encoding
// and a small conditional-negate helper.
package div_unit_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_CALC  = 2'd2,
      S_END   = 2'd3
   } div_state_e;

   // Two's-complement negate when neg is set, pass-through otherwise.
   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] value,
                                                input logic            neg);
      logic [XLEN-1:0] res;
      if (neg) begin
         res = ~value + {{(XLEN-1){1'b0}}, 1'b1};
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// div_unit_if: request / write-back bundle between EX decode, the divider and
// the register-file write port. master = EX side, slave = divider.
interface div_unit_if;
   import div_unit_pkg::*;

   logic                  start_i;
   logic [2:0]            op_i;
   logic [XLEN-1:0]       dividend_i;
   logic [XLEN-1:0]       divisor_i;
   logic [REG_ADDR_W-1:0] waddr_i;
   logic                  flush_i;
   logic                  busy_o;
   logic                  ready_o;
   logic [XLEN-1:0]       result_o;
   logic                  reg_we_o;
   logic [REG_ADDR_W-1:0] reg_waddr_o;

   modport master (
      output start_i, op_i, dividend_i, divisor_i, waddr_i, flush_i,
      input  busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
   );

   modport slave (
      input  start_i, op_i, dividend_i, divisor_i, waddr_i, flush_i,
      output busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
   );

endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divider (DIV/DIVU/REM/REMU), one restoring
// quotient bit per cycle, single-cycle write-back toward the register file.
// Optional build macro DIV_EARLY_OUT_EN: finish in CHECK when
// |dividend| < |divisor| (quotient 0, remainder = dividend).
// All outputs are registered: the values presented in END are computed on
// the transition into END.
module div_unit
   import div_unit_pkg::*;
(
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);

   div_state_e            state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       dvd_q, dvd_d;     // raw dividend as latched
   logic [XLEN-1:0]       dvs_q, dvs_d;     // raw divisor, |divisor| once in CALC
   logic [XLEN-1:0]       quo_q, quo_d;     // dividend bits out, quotient bits in
   logic [XLEN-1:0]       rem_q, rem_d;     // partial remainder
   logic [4:0]            cnt_q, cnt_d;
   logic                  neg_quo_q, neg_quo_d;
   logic                  neg_rem_q, neg_rem_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic [XLEN-1:0]       result_q, result_d;
   logic [REG_ADDR_W-1:0] wb_addr_q, wb_addr_d;

   logic                  is_signed_s;
   logic                  sel_rem_s;
   logic [XLEN-1:0]       dvd_abs_s;
   logic [XLEN-1:0]       dvs_abs_s;
   logic                  div_zero_s;
   logic                  ovf_s;
   logic [XLEN:0]         partial_s;
   logic [XLEN:0]         diff_s;
   logic [XLEN-1:0]       step_quo_s;
   logic [XLEN-1:0]       step_rem_s;

   // Operand conditioning and the single restoring-division step.
   always_comb begin
      is_signed_s = (op_q == F3_DIV) || (op_q == F3_REM);
      sel_rem_s   = op_q[1];
      dvd_abs_s   = cond_neg(dvd_q, is_signed_s & dvd_q[XLEN-1]);
      dvs_abs_s   = cond_neg(dvs_q, is_signed_s & dvs_q[XLEN-1]);
      div_zero_s  = (dvs_q == {XLEN{1'b0}});
      ovf_s       = is_signed_s
                    && (dvd_q == {1'b1, {(XLEN-1){1'b0}}})
                    && (dvs_q == {XLEN{1'b1}});
      // Shift the next dividend bit in; a negative difference means restore.
      partial_s   = {rem_q, quo_q[XLEN-1]};
      diff_s      = partial_s - {1'b0, dvs_q};
      step_quo_s  = {quo_q[XLEN-2:0], ~diff_s[XLEN]};
      step_rem_s  = diff_s[XLEN] ? partial_s[XLEN-1:0] : diff_s[XLEN-1:0];
   end

   // Next-state and next-output logic of the divider FSM.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      waddr_d   = waddr_q;
      dvd_d     = dvd_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = {XLEN{1'b0}};

      case (state_q)
         S_IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
               op_d    = bus.op_i;
               dvd_d   = bus.dividend_i;
               dvs_d   = bus.divisor_i;
               waddr_d = bus.waddr_i;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else if (div_zero_s) begin
               result_d = sel_rem_s ? dvd_q : {XLEN{1'b1}};
               state_d  = S_END;
            end else if (ovf_s) begin
               result_d = sel_rem_s ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
               state_d  = S_END;
`ifdef DIV_EARLY_OUT_EN
            end else if (dvd_abs_s < dvs_abs_s) begin
               result_d = sel_rem_s ? dvd_q : {XLEN{1'b0}};
               state_d  = S_END;
`endif
            end else begin
               quo_d     = dvd_abs_s;
               dvs_d     = dvs_abs_s;
               rem_d     = {XLEN{1'b0}};
               cnt_d     = 5'd0;
               neg_quo_d = is_signed_s & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
               neg_rem_d = is_signed_s & dvd_q[XLEN-1];
               state_d   = S_CALC;
            end
         end
         S_CALC: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else begin
               quo_d = step_quo_s;
               rem_d = step_rem_s;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  result_d = sel_rem_s ? cond_neg(step_rem_s, neg_rem_q)
                                       : cond_neg(step_quo_s, neg_quo_q);
                  state_d  = S_END;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_END: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d    = (state_d != S_IDLE);
      ready_d   = (state_d == S_END);
      wb_addr_d = ready_d ? waddr_q : {REG_ADDR_W{1'b0}};
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= 3'b000;
         waddr_q   <= {REG_ADDR_W{1'b0}};
         dvd_q     <= {XLEN{1'b0}};
         dvs_q     <= {XLEN{1'b0}};
         quo_q     <= {XLEN{1'b0}};
         rem_q     <= {XLEN{1'b0}};
         cnt_q     <= 5'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= {XLEN{1'b0}};
         wb_addr_q <= {REG_ADDR_W{1'b0}};
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         waddr_q   <= waddr_d;
         dvd_q     <= dvd_d;
         dvs_q     <= dvs_d;
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         result_q  <= result_d;
         wb_addr_q <= wb_addr_d;
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.ready_o     = ready_q;
   assign bus.reg_we_o    = ready_q;
   assign bus.result_o    = result_q;
   assign bus.reg_waddr_o = wb_addr_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Stimulus pushes the expected
// write-back (value, rd, issue cycle, latency) computed with plain SV
// arithmetic; an independent monitor pops and compares on every ready pulse.
module tb_div_unit;
   import div_unit_pkg::*;

`ifdef DIV_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   typedef struct {
      logic [31:0] res;
      logic [4:0]  rd;
      int          t;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   exp_t sb_q[$];

   div_unit_if bus();

   div_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: RISC-V M-extension semantics in plain arithmetic.
   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      int sa;
      int sb;
      bit ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
      case (op)
         3'b100:  return (b == 32'd0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
         3'b101:  return (b == 32'd0) ? 32'hFFFFFFFF : a / b;
         3'b110:  return (b == 32'd0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      bit          sgn;
      logic [31:0] ma;
      logic [31:0] mb;
      sgn = (op == 3'b100) || (op == 3'b110);
      ma  = (sgn && a[31]) ? 32'd0 - a : a;
      mb  = (sgn && b[31]) ? 32'd0 - b : b;
      if (b == 32'd0) return 2;
      if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return 2;
      if (EARLY && ma < mb) return 2;
      return 34;
   endfunction

   // Issue one op at the current negedge (cycle T) and follow it to completion.
   // flush_at / restart_at: cycle offset from T for a flush or stray start, 0 = none.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int flush_at, input int restart_at);
      int   t0;
      int   lat;
      int   last;
      int   pulses;
      exp_t e;
      t0  = cyc;
      lat = exp_lat(op, a, b);
      bus.start_i    = 1'b1;
      bus.op_i       = op;
      bus.dividend_i = a;
      bus.divisor_i  = b;
      bus.waddr_i    = rd;
      if (flush_at == 0) begin
         e.res = ref_result(op, a, b);
         e.rd  = rd;
         e.t   = t0;
         e.lat = lat;
         sb_q.push_back(e);
      end
      last   = (flush_at != 0) ? flush_at + 40 : lat + 1;
      pulses = 0;
      for (int k = 1; k <= last; k++) begin
         @(negedge clk);
         bus.start_i = 1'b0;
         bus.flush_i = 1'b0;
         if (k == 1) check("busy_after_start", 32'(bus.busy_o), 32'd1);
         if (k == restart_at) begin
            bus.start_i    = 1'b1;
            bus.op_i       = 3'($urandom_range(4, 7));
            bus.dividend_i = $urandom;
            bus.divisor_i  = $urandom;
            bus.waddr_i    = ~rd;
         end
         if (k == flush_at) bus.flush_i = 1'b1;
         if (flush_at == 0 && k == lat) check("busy_in_end", 32'(bus.busy_o), 32'd1);
         if (flush_at == 0 && k == lat + 1) check("busy_after_end", 32'(bus.busy_o), 32'd0);
         if (flush_at != 0 && k == flush_at + 1) check("busy_after_flush", 32'(bus.busy_o), 32'd0);
         if (bus.ready_o) pulses++;
      end
      if (flush_at != 0) check("flushed_no_wb", 32'(pulses), 32'd0);
   endtask

   // Monitor: compares every write-back against the scoreboard head.
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.ready_o) begin
            if (sb_q.size() == 0) begin
               check("unexpected_ready", 32'(bus.ready_o), 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("result", bus.result_o, e.res);
               check("reg_waddr", 32'(bus.reg_waddr_o), 32'(e.rd));
               check("reg_we", 32'(bus.reg_we_o), 32'd1);
               check("latency", 32'(cyc - e.t), 32'(e.lat));
            end
         end else begin
            check("idle_outputs", {bus.reg_we_o, bus.reg_waddr_o, 26'd0} | bus.result_o, 32'd0);
            if (sb_q.size() > 0 && (cyc - sb_q[0].t) > 40) begin
               check("ready_timeout", 32'd0, 32'd1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          pulses;
      int          sel;
      bus.start_i    = 1'b0;
      bus.op_i       = 3'b000;
      bus.dividend_i = 32'd0;
      bus.divisor_i  = 32'd0;
      bus.waddr_i    = 5'd0;
      bus.flush_i    = 1'b0;

      repeat (3) @(negedge clk);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_ready", 32'(bus.ready_o), 32'd0);
      check("rst_we", 32'(bus.reg_we_o), 32'd0);
      check("rst_result", bus.result_o, 32'd0);
      check("rst_waddr", 32'(bus.reg_waddr_o), 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      // Directed cases from the plan.
      check("idle_busy", 32'(bus.busy_o), 32'd0);
      run_op(3'b101, 32'd100, 32'd7, 5'd5, 0, 0);
      run_op(3'b110, 32'hFFFFFFF9, 32'd2, 5'd6, 0, 0);
      run_op(3'b100, 32'hFFFFFFF9, 32'd2, 5'd7, 0, 0);
      run_op(3'b100, 32'd1234, 32'd0, 5'd8, 0, 0);
      run_op(3'b110, 32'd1234, 32'd0, 5'd9, 0, 0);
      run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd10, 0, 0);
      run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd11, 0, 0);
      run_op(3'b101, 32'd3, 32'd10, 5'd12, 0, 0);
      run_op(3'b111, 32'd3, 32'd10, 5'd13, 0, 0);
      run_op(3'b101, 32'd100000, 32'd3, 5'd14, 10, 0);
      run_op(3'b101, 32'd100000, 32'd3, 5'd15, 0, 5);
      run_op(3'b100, 32'd77, 32'd5, 5'd0, 0, 0);

      // Start together with flush in IDLE is dropped.
      bus.start_i    = 1'b1;
      bus.flush_i    = 1'b1;
      bus.op_i       = 3'b101;
      bus.dividend_i = 32'd50;
      bus.divisor_i  = 32'd5;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      check("start_with_flush", 32'(bus.busy_o), 32'd0);

      // Reset in the middle of an operation: no write-back afterwards.
      bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("busy_after_rst", 32'(bus.busy_o), 32'd0);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.ready_o) pulses++;
      end
      check("rst_no_wb", 32'(pulses), 32'd0);

      // Randomized operations.
      for (int n = 0; n < 60; n++) begin
         op  = 3'($urandom_range(4, 7));
         sel = $urandom_range(0, 7);
         a   = $urandom;
         b   = $urandom >> $urandom_range(0, 31);
         if (sel == 0) b = 32'd0;
         if (sel == 1) begin
            a = 32'h80000000;
            b = 32'hFFFFFFFF;
         end
         if (sel == 2) begin
            a = 32'($urandom_range(0, 20));
            b = 32'($urandom_range(21, 100));
         end
         if (sel == 3) b = ~b;
         run_op(op, a, b, 5'($urandom_range(0, 31)), 0, 0);
      end

      repeat (5) @(negedge clk);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
